// File: rtl/instr_issue_queue_if.sv
// Decode-push / back-end-issue bundle for instr_issue_queue.
// slave is the queue's view, master is the decode + ROB/RS environment.
interface instr_issue_queue_if;
  logic        push;
  logic [3:0]  push_op;
  logic [4:0]  push_rd;
  logic [4:0]  push_rs1;
  logic [4:0]  push_rs2;
  logic [31:0] push_imm;
  logic [31:0] push_pc;
  logic        iq_full;
  logic        rob_full;
  logic        rs_full;
  logic [2:0]  rob_curr_ptr;
  logic        ld_pc;
  logic        rob_load;
  logic [3:0]  instr_type;
  logic [4:0]  rd;
  logic [4:0]  st_src;
  logic        rs_load;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [31:0] imm_o;
  logic [31:0] pc_o;
  logic [2:0]  rob_tag;

  modport slave (
    input  push, push_op, push_rd, push_rs1, push_rs2, push_imm, push_pc,
    input  rob_full, rs_full, rob_curr_ptr, ld_pc,
    output iq_full, rob_load, instr_type, rd, st_src, rs_load,
    output rs1_o, rs2_o, imm_o, pc_o, rob_tag
  );

  modport master (
    output push, push_op, push_rd, push_rs1, push_rs2, push_imm, push_pc,
    output rob_full, rs_full, rob_curr_ptr, ld_pc,
    input  iq_full, rob_load, instr_type, rd, st_src, rs_load,
    input  rs1_o, rs2_o, imm_o, pc_o, rob_tag
  );
endinterface

// File: rtl/instr_issue_queue.sv
// In-order instruction issue queue between decode and the Tomasulo back end.
// Optional feature: define IQ_BYPASS_EN to issue a push straight through when the queue is empty.
module instr_issue_queue #(
  parameter int         DEPTH     = 8,
  parameter logic [3:0] OP_BRANCH = 4'b0110
) (
  input logic               clk,
  input logic               rst,
  instr_issue_queue_if.slave iq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] pc;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  logic   empty;
  logic   full;
  logic   push_ok;
  logic   issue_ok;
  logic   bypass;
  logic   fire;
  logic   wr_en;
  logic   is_store;
  logic   is_branch;
  entry_t push_entry;
  entry_t issue_e;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign push_ok  = iq.push & ~full & ~iq.ld_pc;
  assign issue_ok = ~empty & ~iq.rob_full & ~iq.rs_full & ~iq.ld_pc;

`ifdef IQ_BYPASS_EN
  assign bypass = empty & iq.push & ~iq.rob_full & ~iq.rs_full & ~iq.ld_pc;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed push goes straight to the back end and never occupies a slot.
  assign fire  = issue_ok | bypass;
  assign wr_en = push_ok & ~bypass;

  always_comb begin
    push_entry.op  = iq.push_op;
    push_entry.rd  = iq.push_rd;
    push_entry.rs1 = iq.push_rs1;
    push_entry.rs2 = iq.push_rs2;
    push_entry.imm = iq.push_imm;
    push_entry.pc  = iq.push_pc;
  end

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (iq.ld_pc) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en) begin
        mem_d[tail_q] = push_entry;
        tail_d        = tail_q + PW'(1);
      end
      if (issue_ok) begin
        head_d = head_q + PW'(1);
      end
      count_d = count_q + CW'(wr_en) - CW'(issue_ok);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  // Head is presented whenever the queue holds something, even while stalled.
  always_comb begin
    issue_e = '0;
    if (bypass) begin
      issue_e = push_entry;
    end else if (!empty) begin
      issue_e = mem_q[head_q];
    end
  end

  assign is_store  = issue_e.op[3];
  assign is_branch = (issue_e.op == OP_BRANCH);

  assign iq.iq_full    = full;
  assign iq.rob_load   = fire;
  assign iq.rs_load    = fire;
  assign iq.instr_type = issue_e.op;
  assign iq.rd         = (is_store | is_branch) ? 5'd0 : issue_e.rd;
  assign iq.st_src     = is_store ? issue_e.rs2 : 5'd0;
  assign iq.rs1_o      = issue_e.rs1;
  assign iq.rs2_o      = issue_e.rs2;
  assign iq.imm_o      = issue_e.imm;
  assign iq.pc_o       = issue_e.pc;
  assign iq.rob_tag    = fire ? iq.rob_curr_ptr : 3'd0;

endmodule

// File: tb/tb_instr_issue_queue.sv
// Scoreboard bench for instr_issue_queue: driver queues expected issues, a negedge monitor checks them.
module tb_instr_issue_queue;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SW     = 4'b1010;
  localparam logic [3:0] OP_BRANCH = 4'b0110;
  localparam int         DEPTH     = 8;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  st_src;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] pc;
  } exp_t;

  logic clk;
  logic rst;
  instr_issue_queue_if iq ();

  instr_issue_queue #(.DEPTH(DEPTH), .OP_BRANCH(OP_BRANCH)) dut (
    .clk (clk),
    .rst (rst),
    .iq  (iq)
  );

  exp_t       sbq[$];
  int         model_count;
  logic [2:0] ptr_var;
  int         compared;
  int         mismatched;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One driven cycle; also advances the reference occupancy model.
  task automatic applyStimulus(input logic p, input logic [3:0] op, input logic [4:0] rd_i,
                               input logic [4:0] rs1_i, input logic [4:0] rs2_i,
                               input logic [31:0] imm_i, input logic [31:0] pc_i,
                               input logic robf, input logic rsf, input logic ldpc);
    logic can_issue;
    logic byp;
    logic acc;
    exp_t e;
    @(posedge clk);
    #1;
    iq.push         = p;
    iq.push_op      = op;
    iq.push_rd      = rd_i;
    iq.push_rs1     = rs1_i;
    iq.push_rs2     = rs2_i;
    iq.push_imm     = imm_i;
    iq.push_pc      = pc_i;
    iq.rob_full     = robf;
    iq.rs_full      = rsf;
    iq.ld_pc        = ldpc;
    ptr_var         = ptr_var + 3'd1;
    iq.rob_curr_ptr = ptr_var;
    can_issue = (model_count != 0) && !robf && !rsf && !ldpc;
    byp = 1'b0;
`ifdef IQ_BYPASS_EN
    byp = (model_count == 0) && p && !robf && !rsf && !ldpc;
`endif
    acc = p && !ldpc && (model_count < DEPTH) && !byp;
    e.op     = op;
    e.rd     = (op[3] || op == OP_BRANCH) ? 5'd0 : rd_i;
    e.st_src = op[3] ? rs2_i : 5'd0;
    e.rs1    = rs1_i;
    e.rs2    = rs2_i;
    e.imm    = imm_i;
    e.pc     = pc_i;
    if (ldpc) begin
      sbq.delete();
      model_count = 0;
    end else begin
      if (acc || byp) sbq.push_back(e);
      model_count = model_count + int'(acc) - int'(can_issue);
    end
  endtask

  task automatic idleCycle(input logic robf, input logic rsf);
    applyStimulus(1'b0, OP_ADD, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, robf, rsf, 1'b0);
  endtask

  task automatic pushCycle(input logic [3:0] op, input logic [4:0] rd_i, input logic [31:0] pc_i,
                           input logic robf);
    applyStimulus(1'b1, op, rd_i, rd_i + 5'd1, rd_i + 5'd2, pc_i + 32'h10, pc_i, robf, 1'b0, 1'b0);
  endtask

  // Monitor: every issue strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && iq.rob_load === 1'b1) begin
      if (sbq.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_issue: got issue of pc %0h, expected no issue", iq.pc_o);
      end else begin
        e = sbq.pop_front();
        checkOutput("issue_pc", 64'(iq.pc_o), 64'(e.pc));
        checkOutput("issue_type", 64'(iq.instr_type), 64'(e.op));
        checkOutput("issue_rd", 64'(iq.rd), 64'(e.rd));
        checkOutput("issue_st_src", 64'(iq.st_src), 64'(e.st_src));
        checkOutput("issue_rs1", 64'(iq.rs1_o), 64'(e.rs1));
        checkOutput("issue_rs2", 64'(iq.rs2_o), 64'(e.rs2));
        checkOutput("issue_imm", 64'(iq.imm_o), 64'(e.imm));
        checkOutput("issue_tag", 64'(iq.rob_tag), 64'(iq.rob_curr_ptr));
        checkOutput("issue_rs_load", 64'(iq.rs_load), 64'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compared        = 0;
    mismatched      = 0;
    model_count     = 0;
    ptr_var         = 3'd0;
    rst             = 1'b1;
    iq.push         = 1'b0;
    iq.push_op      = '0;
    iq.push_rd      = '0;
    iq.push_rs1     = '0;
    iq.push_rs2     = '0;
    iq.push_imm     = '0;
    iq.push_pc      = '0;
    iq.rob_full     = 1'b0;
    iq.rs_full      = 1'b0;
    iq.rob_curr_ptr = '0;
    iq.ld_pc        = 1'b0;

    @(negedge clk);
    checkOutput("reset_rob_load", 64'(iq.rob_load), 64'd0);
    checkOutput("reset_iq_full", 64'(iq.iq_full), 64'd0);
    checkOutput("reset_pc_o", 64'(iq.pc_o), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Push-to-issue latency
    pushCycle(OP_ADD, 5'd3, 32'h1000, 1'b0);
    @(negedge clk);
`ifdef IQ_BYPASS_EN
    checkOutput("lat_cycle0", 64'(iq.rob_load), 64'd1);
`else
    checkOutput("lat_cycle0", 64'(iq.rob_load), 64'd0);
`endif
    idleCycle(1'b0, 1'b0);
    @(negedge clk);
`ifdef IQ_BYPASS_EN
    checkOutput("lat_cycle1", 64'(iq.rob_load), 64'd0);
`else
    checkOutput("lat_cycle1", 64'(iq.rob_load), 64'd1);
`endif

    // Store and branch destination forcing
    applyStimulus(1'b1, OP_SW, 5'd9, 5'd4, 5'd7, 32'h20, 32'h1004, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_BRANCH, 5'd5, 5'd6, 5'd8, 32'h40, 32'h1008, 1'b0, 1'b0, 1'b0);
    idleCycle(1'b0, 1'b0);
    idleCycle(1'b0, 1'b0);

    // Fill under rob_full, reject the 9th, then drain in order
    for (int i = 0; i < DEPTH; i++) pushCycle(OP_ADD, 5'(i + 1), 32'h2000 + 32'(i * 4), 1'b1);
    pushCycle(OP_ADD, 5'd20, 32'h2100, 1'b1);
    @(negedge clk);
    checkOutput("full_after_8", 64'(iq.iq_full), 64'd1);
    checkOutput("full_no_issue", 64'(iq.rob_load), 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      idleCycle(1'b0, 1'b0);
      @(negedge clk);
      checkOutput("burst_rob_load", 64'(iq.rob_load), 64'd1);
    end
    idleCycle(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("burst_drained", 64'(iq.rob_load), 64'd0);
    checkOutput("burst_not_full", 64'(iq.iq_full), 64'd0);

    // rs_full stall holds the head steady
    applyStimulus(1'b1, OP_ADD, 5'd11, 5'd12, 5'd13, 32'h77, 32'h2200, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      idleCycle(1'b0, 1'b1);
      @(negedge clk);
      checkOutput("stall_rob_load", 64'(iq.rob_load), 64'd0);
      checkOutput("stall_pc_held", 64'(iq.pc_o), 64'h2200);
    end
    idleCycle(1'b0, 1'b0);

    // Flush with a concurrent push, then a new-path push while the ROB drains
    for (int i = 0; i < 4; i++) pushCycle(OP_ADD, 5'(i + 2), 32'h3000 + 32'(i * 4), 1'b1);
    applyStimulus(1'b1, OP_ADD, 5'd1, 5'd1, 5'd1, 32'h0, 32'h3100, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("flush_no_issue", 64'(iq.rob_load), 64'd0);
    idleCycle(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("flush_empty", 64'(iq.rob_load), 64'd0);
    checkOutput("flush_not_full", 64'(iq.iq_full), 64'd0);
    pushCycle(OP_ADD, 5'd15, 32'h4000, 1'b1);
    idleCycle(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("newpath_issue", 64'(iq.rob_load), 64'd1);

    // Continuous push and issue across pointer wrap
    pushCycle(OP_ADD, 5'd1, 32'h5000, 1'b0);
    for (int i = 0; i < 20; i++) begin
      pushCycle(OP_ADD, 5'((i % 30) + 1), 32'h5004 + 32'(i * 4), 1'b0);
      @(negedge clk);
      checkOutput("stream_rob_load", 64'(iq.rob_load), 64'd1);
      checkOutput("stream_not_full", 64'(iq.iq_full), 64'd0);
    end
    idleCycle(1'b0, 1'b0);
    idleCycle(1'b0, 1'b0);

    // Asynchronous reset with five entries queued
    for (int i = 0; i < 5; i++) pushCycle(OP_ADD, 5'(i + 1), 32'h6000 + 32'(i * 4), 1'b1);
    @(posedge clk);
    #2;
    iq.push     = 1'b0;
    iq.rob_full = 1'b0;
    rst         = 1'b1;
    sbq.delete();
    model_count = 0;
    @(negedge clk);
    checkOutput("midrst_rob_load", 64'(iq.rob_load), 64'd0);
    checkOutput("midrst_iq_full", 64'(iq.iq_full), 64'd0);
    checkOutput("midrst_pc_o", 64'(iq.pc_o), 64'd0);
    checkOutput("midrst_rd", 64'(iq.rd), 64'd0);
    checkOutput("midrst_rob_tag", 64'(iq.rob_tag), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idleCycle(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("post_reset_empty", 64'(iq.rob_load), 64'd0);

    idleCycle(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("scoreboard_drained", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
